ship_hit_ctl: RTL

Detects collisions between the two enemy missiles and the player ship, the enemy-to-player counterpart of enemy hit detection. Owns the life counter, the post-hit invulnerability window and the game-over flag. Drives the draw enable for the ship drawing stage, which blinks while invulnerable. Sits between the enemy missile controllers and the ship drawing and HUD logic, in the pclk domain.

---
 rtl/game_pkg.sv | 14 +
 rtl/ship_box_hit.sv | 31 +++
 rtl/ship_hit_ctl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Constants and encodings shared by the ship collision controller and the ship drawing stage.
package game_pkg;

  localparam int HALF_WIDTH_SHIP = 25;
  localparam int HEIGHT_SHIP     = 50;
  localparam int SCREEN_WIDTH    = 1024;

  typedef enum logic [1:0] {
    ST_ALIVE = 2'd0,
    ST_INVUL = 2'd1,
    ST_DEAD  = 2'd2
  } ship_state_t;

endpackage

// File: rtl/ship_box_hit.sv
// Combinational box test of one enemy missile against the player ship outline.
module ship_box_hit #(
  parameter int HALF_WIDTH = 25,
  parameter int HEIGHT     = 50
) (
  input  logic        missile_active,
  input  logic [10:0] xpos_missile,
  input  logic [10:0] ypos_missile,
  input  logic [10:0] xpos_ship,
  input  logic [10:0] ypos_ship,
  output logic        hit
);

  logic [11:0] x_lo;
  logic [11:0] x_hi;
  logic [11:0] y_hi;
  logic [11:0] x_m;
  logic [11:0] y_m;

  // Left edge clamps at 0 so a ship near the left border cannot wrap the box.
  assign x_lo = (xpos_ship < 11'(HALF_WIDTH)) ? 12'd0 : ({1'b0, xpos_ship} - 12'(HALF_WIDTH));
  assign x_hi = {1'b0, xpos_ship} + 12'(HALF_WIDTH);
  assign y_hi = {1'b0, ypos_ship} + 12'(HEIGHT);
  assign x_m  = {1'b0, xpos_missile};
  assign y_m  = {1'b0, ypos_missile};

  assign hit = missile_active
             && (x_m >= x_lo) && (x_m <= x_hi)
             && (y_m >= {1'b0, ypos_ship}) && (y_m <= y_hi);

endmodule

// File: rtl/ship_hit_ctl.sv
// Enemy-missile vs player-ship collision, life counter, invulnerability blink and game-over.
//   state    | meaning
//   ST_ALIVE | vulnerable, ship drawn, hits cost a life
//   ST_INVUL | post-hit grace period, hits ignored, ship blinks
//   ST_DEAD  | no lives left, ship hidden, waits for restart
module ship_hit_ctl
  import game_pkg::*;
#(
  parameter int LIVES           = 3,
  parameter int HALF_WIDTH_SHIP = game_pkg::HALF_WIDTH_SHIP,
  parameter int HEIGHT_SHIP     = game_pkg::HEIGHT_SHIP,
  parameter int INVUL_FRAMES    = 120,
  parameter int BLINK_FRAMES    = 8
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        restart,
  input  logic        level_change,
  input  logic [10:0] xpos_ship,
  input  logic [10:0] ypos_ship,
  input  logic [10:0] xpos_missile_1,
  input  logic [10:0] ypos_missile_1,
  input  logic        missile_1_active,
  input  logic [10:0] xpos_missile_2,
  input  logic [10:0] ypos_missile_2,
  input  logic        missile_2_active,
  output logic        ship_on,
  output logic [2:0]  lives,
  output logic        hit_pulse,
  output logic        game_over
);

  localparam logic [2:0] LIVES_INIT = 3'(LIVES);
  localparam logic [7:0] INVUL_INIT = 8'(INVUL_FRAMES);
  localparam logic [7:0] BLINK_TC   = 8'(BLINK_FRAMES);

  logic        hit_1;
  logic        hit_2;
  logic        hit;
  ship_state_t state;
  logic [7:0]  invul_cnt;
  logic [7:0]  blink_cnt;

  ship_box_hit #(.HALF_WIDTH(HALF_WIDTH_SHIP), .HEIGHT(HEIGHT_SHIP)) u_box_1 (
    .missile_active (missile_1_active),
    .xpos_missile   (xpos_missile_1),
    .ypos_missile   (ypos_missile_1),
    .xpos_ship      (xpos_ship),
    .ypos_ship      (ypos_ship),
    .hit            (hit_1)
  );

  ship_box_hit #(.HALF_WIDTH(HALF_WIDTH_SHIP), .HEIGHT(HEIGHT_SHIP)) u_box_2 (
    .missile_active (missile_2_active),
    .xpos_missile   (xpos_missile_2),
    .ypos_missile   (ypos_missile_2),
    .xpos_ship      (xpos_ship),
    .ypos_ship      (ypos_ship),
    .hit            (hit_2)
  );

  // Simultaneous hits from both missiles count as a single hit.
  assign hit = hit_1 | hit_2;

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state     <= ST_ALIVE;
      lives     <= LIVES_INIT;
      ship_on   <= 1'b1;
      game_over <= 1'b0;
      hit_pulse <= 1'b0;
      invul_cnt <= 8'd0;
      blink_cnt <= 8'd0;
    end else begin
      hit_pulse <= 1'b0;
      if (restart) begin
        state     <= ST_ALIVE;
        lives     <= LIVES_INIT;
        ship_on   <= 1'b1;
        game_over <= 1'b0;
        invul_cnt <= 8'd0;
        blink_cnt <= 8'd0;
      end else begin
        case (state)
          ST_ALIVE: begin
            if (!level_change && hit) begin
              hit_pulse <= 1'b1;
              if (lives == 3'd1) begin
                lives     <= 3'd0;
                ship_on   <= 1'b0;
                game_over <= 1'b1;
                state     <= ST_DEAD;
              end else begin
                lives     <= lives - 3'd1;
                invul_cnt <= INVUL_INIT;
                blink_cnt <= 8'd0;
                ship_on   <= 1'b0;
                state     <= ST_INVUL;
              end
            end
          end
          ST_INVUL: begin
            if (level_change) begin
              state     <= ST_ALIVE;
              ship_on   <= 1'b1;
              invul_cnt <= 8'd0;
              blink_cnt <= 8'd0;
            end else if (frame_tick) begin
              if (invul_cnt == 8'd1) begin
                state     <= ST_ALIVE;
                ship_on   <= 1'b1;
                invul_cnt <= 8'd0;
                blink_cnt <= 8'd0;
              end else begin
                invul_cnt <= invul_cnt - 8'd1;
                if (blink_cnt + 8'd1 == BLINK_TC) begin
                  ship_on   <= ~ship_on;
                  blink_cnt <= 8'd0;
                end else begin
                  blink_cnt <= blink_cnt + 8'd1;
                end
              end
            end
          end
          ST_DEAD: begin
            ship_on   <= 1'b0;
            game_over <= 1'b1;
          end
          default: state <= ST_ALIVE;
        endcase
      end
    end
  end

endmodule
